// File: rtl/fp32_pkg.sv
// rtl/fp32_pkg.sv - shared IEEE-754 single-precision constants, operand classes and divider FSM states
package fp32_pkg;

  localparam int          FP_BIAS = 127;
  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
  localparam int          EXP_W   = 8;
  localparam int          MAN_W   = 23;
  localparam int          QBITS   = 25;

  typedef enum logic [1:0] {FP_ZERO, FP_NORM, FP_INF, FP_NAN} fp_class_e;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DIVIDE, S_NORM} div_state_e;

  // Denormals classify as zero: the datapath never produces or consumes them.
  function automatic fp_class_e fp_classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
    if (e == '0)
      return FP_ZERO;
    else if (e == '1)
      return (m == '0) ? FP_INF : FP_NAN;
    else
      return FP_NORM;
  endfunction

endpackage

// File: rtl/fp32_split.sv
// rtl/fp32_split.sv - field extraction of an IEEE-754 single-precision word
module fp32_split
  import fp32_pkg::*;
(
  input  logic [31:0]      x,
  output logic             sign,
  output logic [EXP_W-1:0] exp,
  output logic [MAN_W-1:0] man
);

  assign sign = x[31];
  assign exp  = x[30:23];
  assign man  = x[22:0];

endmodule

// File: rtl/mant_div_iter.sv
// rtl/mant_div_iter.sv - radix-2 restoring mantissa divider, one quotient bit per step, MSB first
module mant_div_iter
  import fp32_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [MAN_W:0]   ma,
  input  logic [MAN_W:0]   mb,
  output logic [QBITS-1:0] q,
  output logic             last
);

  // Remainder stays below 2*mb, so one extra bit over the mantissa is enough.
  logic [MAN_W+1:0] r;
  logic [MAN_W:0]   d;
  logic [4:0]       cnt;
  logic             ge;
  logic [MAN_W+1:0] diff;

  always_comb begin
    ge   = (r >= {1'b0, d});
    diff = ge ? (r - {1'b0, d}) : r;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r   <= '0;
      d   <= '0;
      q   <= '0;
      cnt <= '0;
    end else if (load) begin
      r   <= {1'b0, ma};
      d   <= mb;
      q   <= '0;
      cnt <= '0;
    end else if (step) begin
      q   <= {q[QBITS-2:0], ge};
      r   <= {diff[MAN_W:0], 1'b0};
      cnt <= cnt + 5'd1;
    end
  end

  assign last = (cnt == 5'(QBITS - 1));

endmodule

// File: rtl/float_div_seq.sv
// rtl/float_div_seq.sv - iterative single-precision divider with start/done handshake and fixed latency
module float_div_seq
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] num_1,
  input  logic [31:0] num_2,
  output logic        busy,
  output logic        done,
  output logic [31:0] out
);

  div_state_e        state, state_nx;
  logic [31:0]       a_q, b_q;
  logic              s1, s2;
  logic [EXP_W-1:0]  e1, e2;
  logic [MAN_W-1:0]  m1, m2;
  fp_class_e         c1, c2;
  logic              special_nx, special_q, sign_q;
  logic [31:0]       special_val_nx, special_val_q, result;
  logic signed [9:0] exp_t_nx, exp_t_q, exp_n;
  logic [MAN_W-1:0]  frac_n;
  logic [QBITS-1:0]  q;
  logic              accept, div_load, div_step, div_last;

  fp32_split u_split_1 (.x(a_q), .sign(s1), .exp(e1), .man(m1));
  fp32_split u_split_2 (.x(b_q), .sign(s2), .exp(e2), .man(m2));

  mant_div_iter u_mant_div (
    .clk  (clk),
    .rst  (rst),
    .load (div_load),
    .step (div_step),
    .ma   ({1'b1, m1}),
    .mb   ({1'b1, m2}),
    .q    (q),
    .last (div_last)
  );

  // The done cycle blocks acceptance so a held start cannot retrigger back-to-back.
  assign accept = (state == S_IDLE) && start && !done;

  always_comb begin
    state_nx = state;
    div_load = 1'b0;
    div_step = 1'b0;
    case (state)
      S_IDLE:   if (accept) state_nx = S_LOAD;
      S_LOAD:   begin div_load = 1'b1; state_nx = S_DIVIDE; end
      S_DIVIDE: begin div_step = 1'b1; if (div_last) state_nx = S_NORM; end
      S_NORM:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    c1             = fp_classify(e1, m1);
    c2             = fp_classify(e2, m2);
    exp_t_nx       = $signed({2'b00, e1}) - $signed({2'b00, e2}) + 10'(FP_BIAS);
    special_nx     = 1'b1;
    special_val_nx = FP_QNAN;
    if (c1 == FP_NAN || c2 == FP_NAN || (c1 == FP_ZERO && c2 == FP_ZERO) ||
        (c1 == FP_INF && c2 == FP_INF))
      special_val_nx = FP_QNAN;
    else if (c2 == FP_ZERO || c1 == FP_INF)
      special_val_nx = {s1 ^ s2, 8'hFF, 23'h0};
    else if (c1 == FP_ZERO || c2 == FP_INF)
      special_val_nx = {s1 ^ s2, 31'h0};
    else
      special_nx = 1'b0;
  end

  always_comb begin
    if (q[QBITS-1]) begin
      frac_n = q[MAN_W:1];
      exp_n  = exp_t_q;
    end else begin
      frac_n = q[MAN_W-1:0];
      exp_n  = exp_t_q - 10'sd1;
    end
    if (special_q)
      result = special_val_q;
    else if (exp_n >= 10'sd255)
      result = {sign_q, 8'hFF, 23'h0};
    else if (exp_n <= 10'sd0)
      result = {sign_q, 31'h0};
    else
      result = {sign_q, exp_n[7:0], frac_n};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q           <= '0;
      b_q           <= '0;
      sign_q        <= 1'b0;
      exp_t_q       <= '0;
      special_q     <= 1'b0;
      special_val_q <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      out           <= '0;
    end else begin
      done <= (state == S_NORM);
      if (accept) begin
        a_q  <= num_1;
        b_q  <= num_2;
        busy <= 1'b1;
      end else if (done) begin
        busy <= 1'b0;
      end
      if (state == S_LOAD) begin
        sign_q        <= s1 ^ s2;
        exp_t_q       <= exp_t_nx;
        special_q     <= special_nx;
        special_val_q <= special_val_nx;
      end
      if (state == S_NORM) out <= result;
    end
  end

endmodule

// File: tb/tb_float_div_seq.sv
// tb/tb_float_div_seq.sv - self-checking bench for float_div_seq: vector table, random ops vs. reference, handshake corners
module tb_float_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] num_1, num_2;
  logic        busy, done;
  logic [31:0] out;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
  } vec_t;

  vec_t tbl[$];

  float_div_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .num_1 (num_1),
    .num_2 (num_2),
    .busy  (busy),
    .done  (done),
    .out   (out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // 0 zero (incl. denormal), 1 normal, 2 infinity, 3 NaN
  function automatic int cls(input logic [31:0] v);
    if (v[30:23] == 8'h00) return 0;
    if (v[30:23] == 8'hFF) return (v[22:0] == 0) ? 2 : 3;
    return 1;
  endfunction

  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic              s;
    int                ca, cb, e;
    longint unsigned   ma, mb, q;
    s  = a[31] ^ b[31];
    ca = cls(a);
    cb = cls(b);
    if (ca == 3 || cb == 3 || (ca == 0 && cb == 0) || (ca == 2 && cb == 2)) return 32'h7FC0_0000;
    if (cb == 0 || ca == 2) return {s, 8'hFF, 23'h0};
    if (ca == 0 || cb == 2) return {s, 31'h0};
    ma = {1'b1, a[22:0]};
    mb = {1'b1, b[22:0]};
    q  = (ma << 24) / mb;
    e  = int'(a[30:23]) - int'(b[30:23]) + 127;
    if (q < (64'd1 << 24)) begin
      q = q << 1;
      e = e - 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0)   return {s, 31'h0};
    return {s, e[7:0], q[23:1]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    int          k;
    v = $urandom;
    k = $urandom_range(0, 15);
    case (k)
      0:       v[30:0]  = '0;
      1:       v[30:0]  = {8'hFF, 23'h0};
      2:       v[30:22] = 9'h1FF;
      3:       v[30:23] = 8'h00;
      default: v[30:23] = 8'($urandom_range(1, 254));
    endcase
    return v;
  endfunction

  // One operation; pulse=1 also fires stray starts at cycles 5, 13, 26 and in the done cycle.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] expv,
                        input bit pulse, input string name);
    int lat;
    bit busy_ok, seen;
    @(negedge clk);
    num_1 = a;
    num_2 = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    lat     = 0;
    busy_ok = 1'b1;
    @(negedge clk);
    start = 1'b0;
    num_1 = $urandom;
    num_2 = $urandom;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      start = pulse && (n == 5 || n == 13 || n == 26);
      num_1 = $urandom;
      num_2 = $urandom;
    end
    check({name, "_latency"}, 32'(lat), 32'd27);
    check({name, "_out"}, out, expv);
    check({name, "_busy_during"}, 32'(busy_ok), 32'd1);
    if (pulse) begin
      @(negedge clk);
      start = 1'b1;
      num_1 = 32'h4120_0000;
      num_2 = 32'h3F80_0000;
    end
    @(posedge clk);
    #1;
    check({name, "_done_pulse"}, {31'h0, done}, 32'd0);
    check({name, "_busy_fall"}, {31'h0, busy}, 32'd0);
    if (pulse) begin
      @(negedge clk);
      start = 1'b0;
      seen  = 1'b0;
      repeat (30) begin
        @(posedge clk);
        #1;
        if (busy || done) seen = 1'b1;
      end
      check({name, "_stray_ignored"}, 32'(seen), 32'd0);
      check({name, "_out_held"}, out, expv);
    end
  endtask

  initial begin
    bit          seen;
    logic [31:0] ra, rb;

    rst   = 1'b1;
    start = 1'b0;
    num_1 = '0;
    num_2 = '0;
    #1;
    check("reset_busy", {31'h0, busy}, 32'd0);
    check("reset_done", {31'h0, done}, 32'd0);
    check("reset_out", out, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    tbl.push_back('{32'h40C0_0000, 32'h4000_0000, 32'h4040_0000});
    tbl.push_back('{32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA});
    tbl.push_back('{32'hC0C0_0000, 32'h4000_0000, 32'hC040_0000});
    tbl.push_back('{32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000});
    tbl.push_back('{32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000});
    tbl.push_back('{32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000});
    tbl.push_back('{32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000});
    tbl.push_back('{32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000});
    tbl.push_back('{32'h0080_0000, 32'h7F00_0000, 32'h0000_0000});
    tbl.push_back('{32'h0000_0001, 32'h3F80_0000, 32'h0000_0000});
    tbl.push_back('{32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000});
    tbl.push_back('{32'hBF80_0000, 32'h7F80_0000, 32'h8000_0000});
    for (int i = 0; i < tbl.size(); i++)
      run_op(tbl[i].a, tbl[i].b, tbl[i].e, 1'b0, $sformatf("vec%0d", i));

    run_op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b1, "stray_start");
    run_op(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 1'b0, "after_stray");

    // Abort mid-operation: outputs clear at once and no result follows.
    @(negedge clk);
    num_1 = 32'h4120_0000;
    num_2 = 32'h4000_0000;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", {31'h0, busy}, 32'd0);
    check("abort_done", {31'h0, done}, 32'd0);
    check("abort_out", out, 32'h0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (busy || done) seen = 1'b1;
    end
    check("abort_no_done", 32'(seen), 32'd0);
    run_op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, "after_abort");

    for (int i = 0; i < 150; i++) begin
      ra = rand_op();
      rb = rand_op();
      run_op(ra, rb, ref_div(ra, rb), 1'b0, $sformatf("rand%0d_%08h_%08h", i, ra, rb));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
